// File: rtl/load_store_unit_pkg.sv
// -----------------------------------------------------------------------------
// load_store_unit_pkg
// Shared types for the load/store unit: the memory operation encoding, the
// FSM state encoding, the wait-counter width and small decode helpers used by
// both the top level and the lane-alignment logic.
// -----------------------------------------------------------------------------
package load_store_unit_pkg;

  // Memory operation carried with each request from the ALU stage.
  typedef enum logic [2:0] {
    LSU_LB  = 3'd0,
    LSU_LBU = 3'd1,
    LSU_LH  = 3'd2,
    LSU_LHU = 3'd3,
    LSU_LW  = 3'd4,
    LSU_SB  = 3'd5,
    LSU_SH  = 3'd6,
    LSU_SW  = 3'd7
  } lsu_op_t;

  // Transaction sequencer states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RESP = 2'd2
  } lsu_state_t;

  localparam int unsigned WAIT_CNT_W = 16;

  // True for operations that read memory.
  function automatic logic lsu_is_load(input lsu_op_t op);
    case (op)
      LSU_LB, LSU_LBU, LSU_LH, LSU_LHU, LSU_LW: return 1'b1;
      default:                                  return 1'b0;
    endcase
  endfunction

  // True when the low address bits do not match the access size.
  function automatic logic lsu_misaligned(input lsu_op_t op, input logic [1:0] lo);
    case (op)
      LSU_LH, LSU_LHU, LSU_SH: return lo[0];
      LSU_LW, LSU_SW:          return (lo != 2'b00);
      default:                 return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/load_store_unit_lane_align.sv
// -----------------------------------------------------------------------------
// lsu_lane_align
// Purely combinational little-endian lane handling for the load/store unit.
//   Store side : st_op, st_sel (addr[1:0]), st_wdata -> byteenable, store_data
//   Load side  : ld_op, ld_sel (addr[1:0]), ld_rdata -> load_data (extended)
// Halfword ops only look at sel[1], so a set bit0 is ignored; word ops ignore
// both low bits.
// -----------------------------------------------------------------------------
module lsu_lane_align
  import load_store_unit_pkg::*;
(
  input  logic [2:0]  st_op,
  input  logic [1:0]  st_sel,
  input  logic [31:0] st_wdata,
  output logic [3:0]  byteenable,
  output logic [31:0] store_data,
  input  logic [2:0]  ld_op,
  input  logic [1:0]  ld_sel,
  input  logic [31:0] ld_rdata,
  output logic [31:0] load_data
);

  lsu_op_t     st_op_s;
  lsu_op_t     ld_op_s;
  logic [7:0]  ld_byte_s;
  logic [15:0] ld_half_s;

  assign st_op_s = lsu_op_t'(st_op);
  assign ld_op_s = lsu_op_t'(ld_op);

  // Lane enables from access size and byte offset.
  always_comb begin
    byteenable = 4'b0000;
    case (st_op_s)
      LSU_LB, LSU_LBU, LSU_SB: byteenable = 4'b0001 << st_sel;
      LSU_LH, LSU_LHU, LSU_SH: byteenable = st_sel[1] ? 4'b1100 : 4'b0011;
      LSU_LW, LSU_SW:          byteenable = 4'b1111;
      default:                 byteenable = 4'b0000;
    endcase
  end

  // Replicate store data across all lanes; byteenable picks the live ones.
  always_comb begin
    store_data = 32'd0;
    case (st_op_s)
      LSU_SB:  store_data = {4{st_wdata[7:0]}};
      LSU_SH:  store_data = {2{st_wdata[15:0]}};
      LSU_SW:  store_data = st_wdata;
      default: store_data = 32'd0;
    endcase
  end

  // Select the addressed byte lane of the read data.
  always_comb begin
    ld_byte_s = 8'd0;
    case (ld_sel)
      2'b00:   ld_byte_s = ld_rdata[7:0];
      2'b01:   ld_byte_s = ld_rdata[15:8];
      2'b10:   ld_byte_s = ld_rdata[23:16];
      2'b11:   ld_byte_s = ld_rdata[31:24];
      default: ld_byte_s = 8'd0;
    endcase
  end

  assign ld_half_s = ld_sel[1] ? ld_rdata[31:16] : ld_rdata[15:0];

  // Extend the selected lane(s) to a full register value.
  always_comb begin
    load_data = 32'd0;
    case (ld_op_s)
      LSU_LB:  load_data = {{24{ld_byte_s[7]}}, ld_byte_s};
      LSU_LBU: load_data = {24'd0, ld_byte_s};
      LSU_LH:  load_data = {{16{ld_half_s[15]}}, ld_half_s};
      LSU_LHU: load_data = {16'd0, ld_half_s};
      LSU_LW:  load_data = ld_rdata;
      default: load_data = 32'd0;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// -----------------------------------------------------------------------------
// load_store_unit
// Memory-access stage: accepts one load/store from the ALU, runs a single
// Avalon-style bus transaction (strobes held through waitrequest) and returns
// an extended load result or store completion to writeback.
//
// Ports
//   clk, reset_n_i                 clock, synchronous active-low reset
//   req_valid_i / req_ready_o      request handshake (ready only in IDLE)
//   req_op_i, req_addr_i,
//   req_wdata_i, req_reg_i         operation, byte address, store data, dest
//   resp_valid_o, resp_rdata_o,
//   resp_reg_o, resp_we_o,
//   resp_err_o                     one-cycle completion to writeback
//   bus_*                          data bus master (word address, lanes)
//
// Parameters
//   WAIT_LIMIT  max wait cycles before a timeout error; 0 disables it.
//
// Build option
//   LSU_ADDR_CHECK_EN  when defined, misaligned H/W requests complete with an
//                      error and no bus cycle; otherwise low bits are ignored.
// -----------------------------------------------------------------------------
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int WAIT_LIMIT = 0
) (
  input  logic        clk,
  input  logic        reset_n_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [2:0]  req_op_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  input  logic [4:0]  req_reg_i,
  output logic        resp_valid_o,
  output logic [31:0] resp_rdata_o,
  output logic [4:0]  resp_reg_o,
  output logic        resp_we_o,
  output logic        resp_err_o,
  output logic [31:0] bus_address_o,
  output logic        bus_read_o,
  output logic        bus_write_o,
  output logic [3:0]  bus_byteenable_o,
  output logic [31:0] bus_writedata_o,
  input  logic [31:0] bus_readdata_i,
  input  logic        bus_waitrequest_i
);

  localparam logic            WD_EN_C = (WAIT_LIMIT != 0);
  localparam logic [WAIT_CNT_W:0] LIMIT_C = (WAIT_CNT_W+1)'(WAIT_LIMIT);

  lsu_state_t            state_r;
  lsu_state_t            next_state_s;
  logic [2:0]            op_r;
  logic [1:0]            addr_lo_r;
  logic [4:0]            reg_r;
  logic [WAIT_CNT_W-1:0] cnt_r;
  logic [WAIT_CNT_W:0]   cnt_inc_s;

  logic        resp_valid_r;
  logic [31:0] resp_rdata_r;
  logic [4:0]  resp_reg_r;
  logic        resp_we_r;
  logic        resp_err_r;
  logic [31:0] bus_address_r;
  logic        bus_read_r;
  logic        bus_write_r;
  logic [3:0]  bus_byteenable_r;
  logic [31:0] bus_writedata_r;

  logic        accept_s;
  logic        addr_err_s;
  logic        req_is_load_s;
  logic        strobe_s;
  logic        done_s;
  logic        timeout_s;
  logic [3:0]  be_s;
  logic [31:0] store_data_s;
  logic [31:0] load_data_s;

  assign req_ready_o   = (state_r == ST_IDLE);
  assign accept_s      = req_valid_i & req_ready_o;
  assign req_is_load_s = lsu_is_load(lsu_op_t'(req_op_i));

`ifdef LSU_ADDR_CHECK_EN
  assign addr_err_s = lsu_misaligned(lsu_op_t'(req_op_i), req_addr_i[1:0]);
`else
  assign addr_err_s = 1'b0;
`endif

  assign strobe_s  = bus_read_r | bus_write_r;
  assign done_s    = (state_r == ST_BUS) & strobe_s & ~bus_waitrequest_i;
  assign cnt_inc_s = {1'b0, cnt_r} + {{WAIT_CNT_W{1'b0}}, 1'b1};
  // Fires on the edge that would complete the WAIT_LIMIT-th wait cycle, so the
  // strobe is visible for exactly WAIT_LIMIT stalled cycles.
  assign timeout_s = WD_EN_C & (state_r == ST_BUS) & strobe_s & bus_waitrequest_i
                     & (cnt_inc_s >= LIMIT_C);

  lsu_lane_align u_lane_align (
    .st_op      (req_op_i),
    .st_sel     (req_addr_i[1:0]),
    .st_wdata   (req_wdata_i),
    .byteenable (be_s),
    .store_data (store_data_s),
    .ld_op      (op_r),
    .ld_sel     (addr_lo_r),
    .ld_rdata   (bus_readdata_i),
    .load_data  (load_data_s)
  );

  // Next-state decode for the transaction sequencer.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          if (addr_err_s) begin
            next_state_s = ST_RESP;
          end else begin
            next_state_s = ST_BUS;
          end
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_BUS: begin
        if (done_s || timeout_s) begin
          next_state_s = ST_RESP;
        end else begin
          next_state_s = ST_BUS;
        end
      end
      ST_RESP: next_state_s = ST_IDLE;
      default: next_state_s = ST_IDLE;
    endcase
  end

  // State, request capture, registered bus/response outputs and wait counter.
  always_ff @(posedge clk) begin
    if (!reset_n_i) begin
      state_r          <= ST_IDLE;
      op_r             <= 3'd0;
      addr_lo_r        <= 2'd0;
      reg_r            <= 5'd0;
      cnt_r            <= '0;
      resp_valid_r     <= 1'b0;
      resp_rdata_r     <= 32'd0;
      resp_reg_r       <= 5'd0;
      resp_we_r        <= 1'b0;
      resp_err_r       <= 1'b0;
      bus_address_r    <= 32'd0;
      bus_read_r       <= 1'b0;
      bus_write_r      <= 1'b0;
      bus_byteenable_r <= 4'd0;
      bus_writedata_r  <= 32'd0;
    end else begin
      state_r      <= next_state_s;
      // Response fields live for a single cycle unless reloaded below.
      resp_valid_r <= 1'b0;
      resp_rdata_r <= 32'd0;
      resp_reg_r   <= 5'd0;
      resp_we_r    <= 1'b0;
      resp_err_r   <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            op_r      <= req_op_i;
            addr_lo_r <= req_addr_i[1:0];
            reg_r     <= req_reg_i;
            cnt_r     <= '0;
            if (addr_err_s) begin
              resp_valid_r <= 1'b1;
              resp_err_r   <= 1'b1;
              resp_reg_r   <= req_reg_i;
            end else begin
              bus_address_r    <= {req_addr_i[31:2], 2'b00};
              bus_read_r       <= req_is_load_s;
              bus_write_r      <= ~req_is_load_s;
              bus_byteenable_r <= be_s;
              bus_writedata_r  <= req_is_load_s ? 32'd0 : store_data_s;
            end
          end
        end
        ST_BUS: begin
          if (done_s || timeout_s) begin
            bus_address_r    <= 32'd0;
            bus_read_r       <= 1'b0;
            bus_write_r      <= 1'b0;
            bus_byteenable_r <= 4'd0;
            bus_writedata_r  <= 32'd0;
            resp_valid_r     <= 1'b1;
            resp_reg_r       <= reg_r;
            if (done_s) begin
              resp_we_r    <= lsu_is_load(lsu_op_t'(op_r));
              resp_rdata_r <= load_data_s;
            end else begin
              resp_err_r   <= 1'b1;
            end
          end else if (bus_waitrequest_i && (cnt_r != {WAIT_CNT_W{1'b1}})) begin
            cnt_r <= cnt_inc_s[WAIT_CNT_W-1:0];
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign resp_valid_o     = resp_valid_r;
  assign resp_rdata_o     = resp_rdata_r;
  assign resp_reg_o       = resp_reg_r;
  assign resp_we_o        = resp_we_r;
  assign resp_err_o       = resp_err_r;
  assign bus_address_o    = bus_address_r;
  assign bus_read_o       = bus_read_r;
  assign bus_write_o      = bus_write_r;
  assign bus_byteenable_o = bus_byteenable_r;
  assign bus_writedata_o  = bus_writedata_r;

endmodule
